// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared types and constants for the divider issue sequencer
package div_seq_pkg;

   localparam int DIV_W = 32;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} div_state_e;

   typedef struct packed {
      logic [DIV_W-1:0] num;
      logic [DIV_W-1:0] den;
   } div_op_t;

   // S_WAIT cycles allowed before the divider's Done is given up on.
   function automatic int timeout_limit(input int tamanyo);
      return 2 * tamanyo + 8;
   endfunction

endpackage

// File: rtl/div_op_fifo.sv
// rtl/div_op_fifo.sv - synchronous operand FIFO with full/empty flags
// Pointers wrap naturally because DEPTH is a power of two.
module div_op_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic         CLK,
   input  logic         RSTa,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/div_issue_seq.sv
// rtl/div_issue_seq.sv - operand FIFO and single-issue sequencer around the signed divider
// Optional S_WAIT watchdog with out_timeout port: define DIV_TIMEOUT_EN.
module div_issue_seq
   import div_seq_pkg::*;
#(
   parameter int TAMANYO    = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [TAMANYO-1:0] in_num,
   input  logic [TAMANYO-1:0] in_den,
   output logic               div_start,
   output logic [TAMANYO-1:0] div_num,
   output logic [TAMANYO-1:0] div_den,
   input  logic [TAMANYO-1:0] div_coc,
   input  logic [TAMANYO-1:0] div_res,
   input  logic               div_done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TAMANYO-1:0] out_coc,
   output logic [TAMANYO-1:0] out_res,
   output logic               out_divzero
`ifdef DIV_TIMEOUT_EN
   ,
   output logic               out_timeout
`endif
);

   div_state_e           state_q, state_d;
   logic [2*TAMANYO-1:0] fifo_rdata;
   logic [TAMANYO-1:0]   head_num, head_den;
   logic                 fifo_full, fifo_empty, fifo_pop, wait_expired;
   logic [TAMANYO-1:0]   div_num_q, div_num_d, div_den_q, div_den_d;
   logic [TAMANYO-1:0]   out_coc_q, out_coc_d, out_res_q, out_res_d;
   logic                 out_valid_q, out_valid_d, out_divzero_q, out_divzero_d;

   div_op_fifo #(
      .W     (2*TAMANYO),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RSTa    (RSTa),
      .push_i  (in_valid),
      .data_i  ({in_num, in_den}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign {head_num, head_den} = fifo_rdata;
   assign in_ready = !fifo_full;
   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

`ifdef DIV_TIMEOUT_EN
   localparam int            TO_LIMIT = timeout_limit(TAMANYO);
   localparam int            CW       = $clog2(TO_LIMIT);
   localparam logic [CW-1:0] TO_LAST  = CW'(TO_LIMIT - 1);

   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          out_timeout_q, out_timeout_d;

   assign wait_expired = (state_q == S_WAIT) && !div_done && (wait_cnt_q == TO_LAST);
   assign out_timeout  = out_timeout_q;
`else
   assign wait_expired = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = (head_den == '0) ? S_HOLD : S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (div_done || wait_expired) state_d = S_HOLD;
         S_HOLD:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_start     = (state_q == S_ISSUE);
      div_num_d     = div_num_q;
      div_den_d     = div_den_q;
      out_coc_d     = out_coc_q;
      out_res_d     = out_res_q;
      out_divzero_d = out_divzero_q;
      out_valid_d   = out_valid_q;
`ifdef DIV_TIMEOUT_EN
      wait_cnt_d    = (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
      out_timeout_d = out_timeout_q;
`endif
      unique case (state_q)
         S_IDLE: if (!fifo_empty) begin
            // Den==0 is answered here so the divider never sees it.
            if (head_den == '0) begin
               out_coc_d     = '1;
               out_res_d     = head_num;
               out_divzero_d = 1'b1;
               out_valid_d   = 1'b1;
`ifdef DIV_TIMEOUT_EN
               out_timeout_d = 1'b0;
`endif
            end else begin
               div_num_d = head_num;
               div_den_d = head_den;
            end
         end
         S_WAIT: if (div_done) begin
            out_coc_d     = div_coc;
            out_res_d     = div_res;
            out_divzero_d = 1'b0;
            out_valid_d   = 1'b1;
`ifdef DIV_TIMEOUT_EN
            out_timeout_d = 1'b0;
`endif
         end else if (wait_expired) begin
            out_coc_d     = '0;
            out_res_d     = '0;
            out_divzero_d = 1'b0;
            out_valid_d   = 1'b1;
`ifdef DIV_TIMEOUT_EN
            out_timeout_d = 1'b1;
`endif
         end
         S_HOLD: if (out_ready) out_valid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         div_num_q     <= '0;
         div_den_q     <= '0;
         out_coc_q     <= '0;
         out_res_q     <= '0;
         out_divzero_q <= 1'b0;
         out_valid_q   <= 1'b0;
`ifdef DIV_TIMEOUT_EN
         wait_cnt_q    <= '0;
         out_timeout_q <= 1'b0;
`endif
      end else begin
         div_num_q     <= div_num_d;
         div_den_q     <= div_den_d;
         out_coc_q     <= out_coc_d;
         out_res_q     <= out_res_d;
         out_divzero_q <= out_divzero_d;
         out_valid_q   <= out_valid_d;
`ifdef DIV_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
         out_timeout_q <= out_timeout_d;
`endif
      end
   end

   assign div_num     = div_num_q;
   assign div_den     = div_den_q;
   assign out_coc     = out_coc_q;
   assign out_res     = out_res_q;
   assign out_divzero = out_divzero_q;
   assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_div_issue_seq.sv
// tb/tb_div_issue_seq.sv - self-checking bench for div_issue_seq with a behavioural divider
module tb_div_issue_seq;

   localparam int T = 32;

   typedef struct packed {
      logic [T-1:0] coc;
      logic [T-1:0] res;
      logic         dz;
   } res_t;

   logic         CLK = 1'b0;
   logic         RSTa = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [T-1:0] in_num = '0;
   logic [T-1:0] in_den = '0;
   logic         div_start;
   logic [T-1:0] div_num, div_den, div_coc, div_res;
   logic         div_done;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [T-1:0] out_coc, out_res;
   logic         out_divzero;
`ifdef DIV_TIMEOUT_EN
   logic         out_timeout;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cnt = 0;
   int overlap_err = 0;
   int hold_err = 0;
   int last_done_cyc = -1000;
   int last_gap = 0;
   bit done_en = 1'b1;
   res_t exp_q[$];
   res_t obs_q[$];

   logic [T-1:0] dv_q = '0, dv_r = '0, dv_junk = '0, dv_num_cap = '0, dv_den_cap = '0;
   logic         dv_busy;
   int           dv_cnt;

   always #5 CLK = ~CLK;

   div_issue_seq #(.TAMANYO(T), .FIFO_DEPTH(4)) dut (
      .CLK         (CLK),
      .RSTa        (RSTa),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_num      (in_num),
      .in_den      (in_den),
      .div_start   (div_start),
      .div_num     (div_num),
      .div_den     (div_den),
      .div_coc     (div_coc),
      .div_res     (div_res),
      .div_done    (div_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_coc     (out_coc),
      .out_res     (out_res),
      .out_divzero (out_divzero)
`ifdef DIV_TIMEOUT_EN
      ,
      .out_timeout (out_timeout)
`endif
   );

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic res_t ref_div(input logic [T-1:0] n, input logic [T-1:0] d);
      res_t r;
      if (d == '0) begin
         r.coc = '1;
         r.res = n;
         r.dz  = 1'b1;
      end else begin
         r.coc = $signed(n) / $signed(d);
         r.res = $signed(n) % $signed(d);
         r.dz  = 1'b0;
      end
      return r;
   endfunction

   // Divider stand-in: Done pulses 2*T+1 cycles after the Start cycle; outputs are junk otherwise.
   always @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         dv_busy  <= 1'b0;
         dv_cnt   <= 0;
         div_done <= 1'b0;
      end else begin
         div_done <= 1'b0;
         dv_junk  <= $urandom;
         if (div_done) last_done_cyc <= cyc;
         if (div_start) begin
            if (dv_busy) overlap_err <= overlap_err + 1;
            start_cnt  <= start_cnt + 1;
            last_gap   <= cyc - last_done_cyc;
            dv_busy    <= 1'b1;
            dv_cnt     <= 2 * T;
            dv_num_cap <= div_num;
            dv_den_cap <= div_den;
            if (div_den != '0) begin
               dv_q <= $signed(div_num) / $signed(div_den);
               dv_r <= $signed(div_num) % $signed(div_den);
            end
         end else if (dv_busy) begin
            if (div_num !== dv_num_cap || div_den !== dv_den_cap) hold_err <= hold_err + 1;
            if (dv_cnt == 1) begin
               div_done <= done_en;
               dv_busy  <= 1'b0;
            end
            dv_cnt <= dv_cnt - 1;
         end
      end
   end

   assign div_coc = div_done ? dv_q : dv_junk;
   assign div_res = div_done ? dv_r : ~dv_junk;

   always @(posedge CLK) begin
      if (RSTa) begin
         if (in_valid && in_ready) exp_q.push_back(ref_div(in_num, in_den));
         if (out_valid && out_ready) obs_q.push_back({out_coc, out_res, out_divzero});
      end
   end

   task automatic push_one(input logic [T-1:0] n, input logic [T-1:0] d, output bit ok);
      in_num = n;
      in_den = d;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (in_ready) begin
            @(negedge CLK);
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output int at, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      at = cyc;
   endtask

   task automatic wait_obs(input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      RSTa = 1'b0;
      repeat (3) @(negedge CLK);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got=%b want=0", div_start); end
      checks++; if ({div_num, div_den} !== '0) begin errors++; $display("FAIL reset_div_ops got=%h/%h want=0/0", div_num, div_den); end
      checks++; if ({out_coc, out_res} !== '0) begin errors++; $display("FAIL reset_out_data got=%h/%h want=0/0", out_coc, out_res); end
      checks++; if (out_divzero !== 1'b0) begin errors++; $display("FAIL reset_divzero got=%b want=0", out_divzero); end
      RSTa = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_basic;
      int c, vc, s0;
      bit ok;
      out_ready = 1'b1;
      s0 = start_cnt;
      c = cyc;
      push_one(32'd100, 32'd7, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_push got=stuck want=accepted"); end
      wait_valid(300, vc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_valid_timeout got=0 want=1"); end
      // one cycle into the FIFO, then 2*T+3 from pop to out_valid
      checks++; if (vc - c !== 68) begin errors++; $display("FAIL basic_latency got=%0d want=68", vc - c); end
      checks++; if (out_coc !== 32'd14) begin errors++; $display("FAIL basic_coc got=%0d want=14", $signed(out_coc)); end
      checks++; if (out_res !== 32'd2) begin errors++; $display("FAIL basic_res got=%0d want=2", $signed(out_res)); end
      checks++; if (out_divzero !== 1'b0) begin errors++; $display("FAIL basic_divzero got=%b want=0", out_divzero); end
      @(negedge CLK);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got=%b want=0", out_valid); end
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_starts got=%0d want=1", start_cnt - s0); end
   endtask

   task automatic test_signed;
      int s0;
      bit ok;
      res_t w0, w1;
      w0 = {32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
      w1 = {32'hFFFF_FFF2, 32'h0000_0002, 1'b0};
      out_ready = 1'b1;
      exp_q.delete(); obs_q.delete();
      s0 = start_cnt;
      push_one(-32'sd100, 32'sd7, ok);
      push_one(32'sd100, -32'sd7, ok);
      wait_obs(2, 400, ok);
      checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL signed_count got=%0d want=2", obs_q.size()); end
      if (obs_q.size() >= 2) begin
         checks++; if (obs_q[0] !== w0) begin errors++; $display("FAIL signed_first got=%h want=%h", obs_q[0], w0); end
         checks++; if (obs_q[1] !== w1) begin errors++; $display("FAIL signed_second got=%h want=%h", obs_q[1], w1); end
      end
      checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL signed_starts got=%0d want=2", start_cnt - s0); end
      checks++; if (last_gap !== 3) begin errors++; $display("FAIL signed_b2b_gap got=%0d want=3", last_gap); end
   endtask

   task automatic test_divzero;
      int c, vc, s0;
      bit ok;
      out_ready = 1'b1;
      s0 = start_cnt;
      c = cyc;
      push_one(32'd5, 32'd0, ok);
      wait_valid(20, vc, ok);
      checks++; if (vc - c !== 2) begin errors++; $display("FAIL dz_latency got=%0d want=2", vc - c); end
      checks++; if (out_coc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_coc got=%h want=ffffffff", out_coc); end
      checks++; if (out_res !== 32'd5) begin errors++; $display("FAIL dz_res got=%0d want=5", out_res); end
      checks++; if (out_divzero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", out_divzero); end
      repeat (4) @(negedge CLK);
      checks++; if (start_cnt !== s0) begin errors++; $display("FAIL dz_no_start got=%0d want=0", start_cnt - s0); end
   endtask

   task automatic test_fill;
      logic [T-1:0] fn[6];
      logic [T-1:0] fd[6];
      int k, drop_at, vc;
      bit ok, acc, stable;
      res_t first, want, got;
      fn = '{32'd1234, -32'sd50, 32'd77, 32'd999999, -32'sd8, 32'd42};
      fd = '{32'd10, 32'd3, 32'd0, -32'sd1000, -32'sd3, 32'd42};
      out_ready = 1'b0;
      exp_q.delete(); obs_q.delete();
      k = 0;
      drop_at = -1;
      for (int i = 0; i < 12; i++) begin
         if (k == 6) break;
         in_valid = 1'b1; in_num = fn[k]; in_den = fd[k];
         acc = in_ready;
         if (!acc && drop_at < 0) drop_at = k;
         @(negedge CLK);
         if (acc) k++;
      end
      checks++; if (drop_at !== 5) begin errors++; $display("FAIL fill_ready_drop got=%0d want=5", drop_at); end
      wait_valid(300, vc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fill_valid_timeout got=0 want=1"); end
      first = {out_coc, out_res, out_divzero};
      want = ref_div(fn[0], fd[0]);
      checks++; if (first !== want) begin errors++; $display("FAIL fill_first got=%h want=%h", first, want); end
      stable = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         if ({out_coc, out_res, out_divzero} !== first || !out_valid || in_ready) stable = 1'b0;
      end
      checks++; if (!stable) begin errors++; $display("FAIL fill_hold got=changed want=stable"); end
      out_ready = 1'b1;
      for (int j = k; j < 6; j++) push_one(fn[j], fd[j], ok);
      wait_obs(6, 2000, ok);
      for (int j = 0; j < 6; j++) begin
         got = (j < obs_q.size()) ? obs_q[j] : '0;
         want = ref_div(fn[j], fd[j]);
         checks++; if (j >= obs_q.size() || got !== want) begin errors++; $display("FAIL fill_drain_%0d got=%h want=%h", j, got, want); end
      end
   endtask

   task automatic test_reset_mid;
      int s0;
      bit ok;
      res_t want;
      out_ready = 1'b1;
      s0 = start_cnt;
      push_one(32'd1000, 32'd3, ok);
      for (int i = 0; i < 20 && start_cnt == s0; i++) @(negedge CLK);
      push_one(32'd9, 32'd9, ok);
      repeat (10) @(negedge CLK);
      #2 RSTa = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
      checks++; if ({div_num, div_den} !== '0) begin errors++; $display("FAIL rmid_div_ops got=%h/%h want=0/0", div_num, div_den); end
      @(negedge CLK);
      RSTa = 1'b1;
      s0 = start_cnt;
      repeat (10) @(negedge CLK);
      checks++; if (start_cnt !== s0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_fifo_empty got=starts%0d/valid%b want=0/0", start_cnt - s0, out_valid); end
      exp_q.delete(); obs_q.delete();
      push_one(32'd77, -32'sd5, ok);
      wait_obs(1, 300, ok);
      want = {32'hFFFF_FFF1, 32'd2, 1'b0};
      checks++; if (obs_q.size() < 1 || obs_q[0] !== want) begin errors++; $display("FAIL rmid_after got=%0d entries want=%h", obs_q.size(), want); end
   endtask

   task automatic test_random;
      localparam int N = 24;
      int push_fail;
      bit ok;
      push_fail = 0;
      exp_q.delete(); obs_q.delete();
      fork
         begin
            logic [T-1:0] n, d;
            bit pok;
            for (int i = 0; i < N; i++) begin
               n = $urandom;
               case ($urandom_range(0, 4))
                  0:       d = '0;
                  1:       begin d = T'($urandom_range(1, 9)); if ($urandom_range(0, 1) == 1) d = -d; end
                  default: d = $urandom;
               endcase
               if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) d = 32'd1;
               push_one(n, d, pok);
               if (!pok) push_fail++;
               repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
         end
         begin
            for (int i = 0; i < 6000 && obs_q.size() < N; i++) begin
               out_ready = ($urandom_range(0, 1) == 1);
               @(negedge CLK);
            end
            out_ready = 1'b1;
         end
      join
      wait_obs(N, 500, ok);
      checks++; if (push_fail !== 0) begin errors++; $display("FAIL rand_push got=%0d stuck want=0", push_fail); end
      checks++; if (obs_q.size() !== N) begin errors++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), N); end
      for (int i = 0; i < N && i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_item_%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (overlap_err !== 0) begin errors++; $display("FAIL one_outstanding got=%0d overlaps want=0", overlap_err); end
      checks++; if (hold_err !== 0) begin errors++; $display("FAIL ops_stable got=%0d changes want=0", hold_err); end
   endtask

`ifdef DIV_TIMEOUT_EN
   task automatic test_timeout;
      int sc, vc;
      bit ok;
      res_t want;
      done_en = 1'b0;
      out_ready = 1'b0;
      sc = cyc;
      push_one(32'd50, 32'd5, ok);
      for (int i = 0; i < 10 && !div_start; i++) @(negedge CLK);
      sc = cyc;
      wait_valid(300, vc, ok);
      checks++; if (vc - sc !== 73) begin errors++; $display("FAIL to_latency got=%0d want=73", vc - sc); end
      checks++; if (out_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got=%b want=1", out_timeout); end
      checks++; if ({out_coc, out_res, out_divzero} !== '0) begin errors++; $display("FAIL to_data got=%h/%h/%b want=0", out_coc, out_res, out_divzero); end
      out_ready = 1'b1;
      @(negedge CLK);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL to_release got=%b want=0", out_valid); end
      done_en = 1'b1;
      repeat (70) @(negedge CLK);
      exp_q.delete(); obs_q.delete();
      push_one(32'd9, 32'd3, ok);
      wait_obs(1, 300, ok);
      want = {32'd3, 32'd0, 1'b0};
      checks++; if (obs_q.size() < 1 || obs_q[0] !== want) begin errors++; $display("FAIL to_next got=%0d entries want=%h", obs_q.size(), want); end
      checks++; if (out_timeout !== 1'b0) begin errors++; $display("FAIL to_cleared got=%b want=0", out_timeout); end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_signed;
      test_divzero;
      test_fill;
      test_reset_mid;
      test_random;
`ifdef DIV_TIMEOUT_EN
      test_timeout;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_issue_seq.md
Name: div_issue_seq

Overview:
- Upstream/downstream wrapper around the algorithmic signed divider.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one division at a time to the divider, capturing its quotient and remainder.
- Returns results on a valid/ready output stream; Den==0 is handled locally and never reaches the divider.

Parameters:
TAMANYO, 32, operand/result width in bits (must match the divider's tamanyo)
FIFO_DEPTH, 4, operand FIFO entries (power of 2, >=2)

Ports:
CLK  in  1  clock, all logic on rising edge
RSTa  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept (not full)
in_num  in  TAMANYO  signed dividend
in_den  in  TAMANYO  signed divisor
div_start  out  1  single-cycle Start pulse to divider
div_num  out  TAMANYO  Num to divider, registered
div_den  out  TAMANYO  Den to divider, registered
div_coc  in  TAMANYO  divider quotient
div_res  in  TAMANYO  divider remainder
div_done  in  1  divider Done pulse
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_coc  out  TAMANYO  signed quotient
out_res  out  TAMANYO  signed remainder
out_divzero  out  1  result came from Den==0 bypass

Behaviour:
- Reset: FIFO empty, FSM=S_IDLE; in_ready=1, div_start=0, div_num=div_den=0, out_valid=0, out_coc=out_res=0, out_divzero=0.
- FIFO: push when in_valid&&in_ready; in_ready=!full (registered count, no same-cycle bypass when full); pop only in S_IDLE on dispatch; push and pop in the same cycle are both allowed when not full; pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - S_IDLE: if FIFO non-empty, pop the head. If den==0, go to S_HOLD with out_coc='1, out_res=num, out_divzero=1, out_valid=1 (1 cycle after pop). Otherwise load div_num/div_den, go to S_ISSUE.
  - S_ISSUE: div_start=1 for exactly this cycle (operands already stable); go to S_WAIT.
  - S_WAIT: on div_done=1, capture div_coc/div_res into out_coc/out_res, set out_divzero=0 and out_valid=1, go to S_HOLD. A div_done in any other state is ignored.
  - S_HOLD: out_* held stable while out_valid&&!out_ready. On out_ready, clear out_valid and go to S_IDLE.
- Back-to-back:
  - div_start never asserted in S_WAIT/S_HOLD; at most one division outstanding.
  - Earliest next div_start is 3 cycles after div_done (HOLD, IDLE, ISSUE) when out_ready=1.
- Nominal latency, pop to out_valid: 2*TAMANYO+3 cycles for Den!=0.
- div_num/div_den hold their value until the next load; they are never driven while the divider is busy.
- Reset mid-operation: everything returns to reset values immediately; the divider shares RSTa, so there is no resync.

Optional Feature:
Macro DIV_TIMEOUT_EN.
- Defined: an S_WAIT cycle counter is added. If div_done has not arrived after 2*TAMANYO+8 cycles, go to S_HOLD with out_coc=0, out_res=0, out_divzero=0 and extra output port out_timeout=1 (cleared on the next result). A late div_done is ignored.
- Undefined: no counter and no out_timeout port; S_WAIT waits indefinitely.

Decomposition:
- Package div_seq_pkg holds:
  - state enum {S_IDLE,S_ISSUE,S_WAIT,S_HOLD};
  - localparam function for the timeout limit;
  - typedef struct for the operand pair.
- Sub-module div_op_fifo: synchronous FIFO parameterised by width/depth, with full/empty flags and async active-low reset.

Test Plan:
- Num=100, Den=7 via real divider: one div_start pulse; out_coc=14, out_res=2, out_divzero=0, 67 cycles after pop.
- Num=-100, Den=7 then Num=100, Den=-7: results (-14,-2) then (-14,2), in order, exactly two div_start pulses.
- Num=5, Den=0: no div_start; out_valid 1 cycle after pop with out_coc=32'hFFFFFFFF, out_res=5, out_divzero=1.
- Push 6 pairs with out_ready=0: in_ready drops after 4 accepted plus 1 in flight; results held stable; releasing out_ready drains all 6 in order.
- RSTa low during S_WAIT: out_valid=0, FIFO empty, in_ready=1 asynchronously; next operand completes correctly.
- DIV_TIMEOUT_EN with div_done tied 0: out_timeout=1 and out_valid=1 after 72 wait cycles; FSM returns to S_IDLE on out_ready.
